// File: rtl/pe_sched.sv
// Round-robin scheduler that shares one processing element (ADD/SUB/MUL/MAC)
// among NUM_REQ requesters. One request is in flight at a time:
// grant -> issue a single-cycle pe_en pulse -> wait for done (or time out)
// -> hold the tagged response until the consumer takes it.
module pe_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ),
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // requester side
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [8*NUM_REQ-1:0] req_c,
    input  logic [2*NUM_REQ-1:0] req_op,
    // processing element side
    output logic [7:0]           pe_a,
    output logic [7:0]           pe_b,
    output logic [7:0]           pe_c,
    output logic [1:0]           pe_op,
    output logic                 pe_en,
    input  logic [15:0]          pe_result,
    input  logic                 pe_done,
    // response side
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] last;       // requester served most recently
    logic [CW-1:0]  cnt;        // WAIT cycles elapsed
    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic           timeout_hit;

    // (base + k) mod NUM_REQ; one extra bit holds the sum before wrapping
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        logic [IDW:0] sum;
        sum = {1'b0, base} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NUM_REQ)) begin
            sum = sum - (IDW+1)'(NUM_REQ);
        end
        return sum[IDW-1:0];
    endfunction

    // Round-robin search: first valid requester after the last one served
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_vld && req_valid[rr_index(last, k)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_index(last, k);
            end
        end
    end

    // Next-state decode plus the combinational one-hot accept
    always_comb begin
        state_nx    = state;
        timeout_hit = 1'b0;
        req_ready   = '0;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nx             = S_ISSUE;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                // done wins over a timeout landing on the same cycle;
                // cnt == TIMEOUT-1 means this is the TIMEOUT-th WAIT cycle
                if (pe_done) begin
                    state_nx = S_RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nx    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register, pe operand/enable registers and response registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state      <= S_IDLE;
            pe_a       <= '0;
            pe_b       <= '0;
            pe_c       <= '0;
            pe_op      <= '0;
            pe_en      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            last       <= IDW'(NUM_REQ - 1);
            cnt        <= '0;
        end else begin
            state <= state_nx;
            pe_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        // operands are sampled only on the grant cycle
                        pe_a   <= req_a[8*grant_idx +: 8];
                        pe_b   <= req_b[8*grant_idx +: 8];
                        pe_c   <= req_c[8*grant_idx +: 8];
                        pe_op  <= req_op[2*grant_idx +: 2];
                        rsp_id <= grant_idx;
                        pe_en  <= 1'b1;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (pe_done) begin
                        rsp_result <= pe_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                    end else if (timeout_hit) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        last      <= rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
